// File: rtl/imm_extend_stage.sv
// Registered immediate extender for ID->EX with a valid/ready handshake.
// Two-entry head/skid buffer keeps accepted immediates while EX stalls.
module imm_extend_stage #(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [IN_WIDTH-1:0]  imediato,
  input  logic [1:0]           modo,
  input  logic [TAG_WIDTH-1:0] tag_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [OUT_WIDTH-1:0] saida,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [1:0]           count
);

  localparam int E = OUT_WIDTH - IN_WIDTH;

  localparam logic [1:0] MODE_ZERO = 2'b00;
  localparam logic [1:0] MODE_SIGN = 2'b01;
  localparam logic [1:0] MODE_UPPR = 2'b10;
  localparam logic [1:0] MODE_BRCH = 2'b11;

  logic [OUT_WIDTH-1:0] w_sext;
  logic [OUT_WIDTH-1:0] w_ext;
  logic                 w_push;
  logic                 w_pop;

  logic [OUT_WIDTH-1:0] r_head_val;
  logic [TAG_WIDTH-1:0] r_head_tag;
  logic [OUT_WIDTH-1:0] r_skid_val;
  logic [TAG_WIDTH-1:0] r_skid_tag;
  logic [1:0]           r_count;

  assign w_sext = {{E{imediato[IN_WIDTH-1]}}, imediato};

  always_comb begin
    w_ext = '0;
    unique case (1'b1)
      (modo == MODE_ZERO): w_ext = {{E{1'b0}}, imediato};
      (modo == MODE_SIGN): w_ext = w_sext;
      (modo == MODE_UPPR): w_ext = {imediato, {E{1'b0}}};
      (modo == MODE_BRCH): w_ext = {w_sext[OUT_WIDTH-3:0], 2'b00};
      default:             w_ext = '0;
    endcase
  end

  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign count     = r_count;
  assign saida     = r_head_val;
  assign tag_out   = r_head_tag;

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_head_val <= '0;
      r_head_tag <= '0;
      r_skid_val <= '0;
      r_skid_tag <= '0;
      r_count    <= 2'd0;
    end else if (flush) begin
      // Payload registers keep their contents; only occupancy is cleared.
      r_count <= 2'd0;
    end else begin
      unique case (r_count)
        2'd0: begin
          if (w_push) begin
            r_head_val <= w_ext;
            r_head_tag <= tag_in;
            r_count    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head_val <= w_ext;
            r_head_tag <= tag_in;
          end else if (w_push) begin
            r_skid_val <= w_ext;
            r_skid_tag <= tag_in;
            r_count    <= 2'd2;
          end else if (w_pop) begin
            r_count <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head_val <= r_skid_val;
            r_head_tag <= r_skid_tag;
            r_count    <= 2'd1;
          end
        end
        default: r_count <= 2'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Scoreboard bench for imm_extend_stage: default widths plus an 8->16 variant.
// Driver queues expected results; a negedge monitor pops and compares.
module tb_imm_extend_stage;

  typedef struct {
    logic [31:0] v;
    logic [4:0]  t;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic [15:0] imediato;
  logic [1:0]  modo;
  logic [4:0]  tag_in;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] saida;
  logic [4:0]  tag_out;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  count;

  logic        flush8;
  logic [7:0]  imm8;
  logic [1:0]  modo8;
  logic [4:0]  tag8;
  logic        inv8;
  logic        rdy8;
  logic [15:0] s8;
  logic [4:0]  t8;
  logic        ov8;
  logic        outr8;
  logic [1:0]  cnt8;

  int   n_checks = 0;
  int   n_fails  = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  imm_extend_stage u_dut (
    .clock     (clk),
    .reset     (reset),
    .flush     (flush),
    .imediato  (imediato),
    .modo      (modo),
    .tag_in    (tag_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .saida     (saida),
    .tag_out   (tag_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count)
  );

  imm_extend_stage #(
    .IN_WIDTH  (8),
    .OUT_WIDTH (16),
    .TAG_WIDTH (5)
  ) u_dut8 (
    .clock     (clk),
    .reset     (reset),
    .flush     (flush8),
    .imediato  (imm8),
    .modo      (modo8),
    .tag_in    (tag8),
    .in_valid  (inv8),
    .in_ready  (rdy8),
    .saida     (s8),
    .tag_out   (t8),
    .out_valid (ov8),
    .out_ready (outr8),
    .count     (cnt8)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] imm, input logic [1:0] m,
                      input logic [4:0] t, input logic [31:0] exp,
                      input bit acc);
    exp_t e;
    imediato = imm;
    modo     = m;
    tag_in   = t;
    in_valid = 1'b1;
    if (acc) begin
      e.v = exp;
      e.t = t;
      q.push_back(e);
    end
    cyc();
    in_valid = 1'b0;
    imediato = 16'hDEAD;
    modo     = 2'b11;
    tag_in   = 5'h1F;
  endtask

  // Monitor: scoreboard pops plus hold-while-stalled checking
  logic        prev_stall = 1'b0;
  logic        prev_rst   = 1'b1;
  logic [31:0] prev_val;
  logic [4:0]  prev_tag;

  always @(negedge clk) begin
    exp_t e;
    if (prev_stall && !prev_rst) begin
      chk("stable_saida", saida, prev_val);
      chk("stable_tag", {27'd0, tag_out}, {27'd0, prev_tag});
    end
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_out: got %h tag %h expected none",
                 saida, tag_out);
      end else begin
        e = q.pop_front();
        chk("sb_saida", saida, e.v);
        chk("sb_tag", {27'd0, tag_out}, {27'd0, e.t});
      end
    end
    prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
    prev_rst   = reset;
    prev_val   = saida;
    prev_tag   = tag_out;
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    imediato = '0; modo = '0; tag_in = '0;
    flush8 = 1'b0; imm8 = '0; modo8 = '0; tag8 = '0;
    inv8 = 1'b0; outr8 = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_saida", saida, 32'd0);
    chk("rst_tag", {27'd0, tag_out}, 32'd0);
    chk("rst_count", {30'd0, count}, 32'd0);

    // All four modes back to back with EX always ready
    out_ready = 1'b1;
    push(16'h8001, 2'b00, 5'd1, 32'h0000_8001, 1'b1);
    chk("lat_zero", saida, 32'h0000_8001);
    push(16'h8001, 2'b01, 5'd2, 32'hFFFF_8001, 1'b1);
    chk("lat_sign", saida, 32'hFFFF_8001);
    push(16'h8001, 2'b10, 5'd3, 32'h8001_0000, 1'b1);
    chk("lat_upper", saida, 32'h8001_0000);
    chk("cnt_stream", {30'd0, count}, 32'd1);
    push(16'h8001, 2'b11, 5'd4, 32'hFFFE_0004, 1'b1);
    chk("lat_branch", saida, 32'hFFFE_0004);
    chk("lat_tag", {27'd0, tag_out}, 32'd4);
    push(16'h7FFF, 2'b01, 5'd5, 32'h0000_7FFF, 1'b1);
    push(16'hFFFF, 2'b11, 5'd6, 32'hFFFF_FFFC, 1'b1);
    cyc();
    chk("drain_count", {30'd0, count}, 32'd0);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure and the full-buffer boundary
    out_ready = 1'b0;
    push(16'h0001, 2'b00, 5'd7, 32'h0000_0001, 1'b1);
    push(16'h0002, 2'b00, 5'd8, 32'h0000_0002, 1'b1);
    chk("bp_count", {30'd0, count}, 32'd2);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    push(16'h0003, 2'b00, 5'd9, 32'h0000_0003, 1'b0);
    chk("bp_head", saida, 32'h0000_0001);
    chk("bp_count2", {30'd0, count}, 32'd2);
    out_ready = 1'b1;
    cyc();
    chk("bp_pop1", saida, 32'h0000_0002);
    chk("bp_pop1_cnt", {30'd0, count}, 32'd1);
    cyc();
    chk("bp_empty", {30'd0, count}, 32'd0);
    chk("bp_hold", saida, 32'h0000_0002);

    // Push and pop in the same cycle at count 1
    out_ready = 1'b0;
    push(16'h0005, 2'b00, 5'd10, 32'h0000_0005, 1'b1);
    out_ready = 1'b1;
    push(16'h0006, 2'b00, 5'd11, 32'h0000_0006, 1'b1);
    chk("pp_count", {30'd0, count}, 32'd1);
    chk("pp_head", saida, 32'h0000_0006);
    cyc();
    chk("pp_drain", {30'd0, count}, 32'd0);

    // Flush at count 2 with a concurrent input
    out_ready = 1'b0;
    push(16'h0010, 2'b00, 5'd12, 32'h0000_0010, 1'b1);
    push(16'h0011, 2'b00, 5'd13, 32'h0000_0011, 1'b1);
    q.delete();
    flush = 1'b1;
    push(16'h0099, 2'b00, 5'd14, 32'h0000_0099, 1'b0);
    flush = 1'b0;
    chk("fl_count", {30'd0, count}, 32'd0);
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_in_ready", {31'd0, in_ready}, 32'd1);
    // Flush at count 0 must also drop a same-cycle push
    flush = 1'b1;
    push(16'h0098, 2'b00, 5'd15, 32'h0000_0098, 1'b0);
    flush = 1'b0;
    chk("fl0_count", {30'd0, count}, 32'd0);
    out_ready = 1'b1;
    cyc();
    cyc();

    // Reset together with flush at count 2
    out_ready = 1'b0;
    push(16'h0030, 2'b00, 5'd16, 32'h0000_0030, 1'b1);
    push(16'h0031, 2'b00, 5'd17, 32'h0000_0031, 1'b1);
    q.delete();
    reset = 1'b1;
    flush = 1'b1;
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    chk("rf_saida", saida, 32'd0);
    chk("rf_tag", {27'd0, tag_out}, 32'd0);
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    chk("rf_count", {30'd0, count}, 32'd0);
    chk("rf_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    push(16'h0040, 2'b00, 5'd18, 32'h0000_0040, 1'b1);
    chk("rf_push_valid", {31'd0, out_valid}, 32'd1);
    chk("rf_push_val", saida, 32'h0000_0040);
    cyc();
    cyc();

    // 8->16 variant
    outr8 = 1'b1;
    imm8 = 8'h80; modo8 = 2'b01; tag8 = 5'd3; inv8 = 1'b1;
    cyc();
    chk("w8_sign", {16'd0, s8}, 32'h0000_FF80);
    chk("w8_valid", {31'd0, ov8}, 32'd1);
    imm8 = 8'h12; modo8 = 2'b10;
    cyc();
    chk("w8_upper", {16'd0, s8}, 32'h0000_1200);
    imm8 = 8'h80; modo8 = 2'b11;
    cyc();
    chk("w8_branch", {16'd0, s8}, 32'h0000_FE00);
    imm8 = 8'h80; modo8 = 2'b00;
    cyc();
    chk("w8_zero", {16'd0, s8}, 32'h0000_0080);
    chk("w8_tag", {27'd0, t8}, 32'd3);
    inv8 = 1'b0;
    cyc();
    chk("w8_drain", {30'd0, cnt8}, 32'd0);

    chk("sb_leftover", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/imm_extend_stage.md
Name: imm_extend_stage

Overview:
- Registered, parametrised immediate-extension stage for the ID pipeline stage.
- Generalises the combinational zero/sign extender:
  - configurable input and output widths
  - four extension modes, including upper-load and branch-offset
  - valid/ready handshake into EX
  - 2-entry skid buffer, so a stalled EX never drops an accepted immediate
  - an ID/EX flush that discards in-flight entries
- A tag (e.g. destination register or PC low bits) travels with each immediate.

Parameters:
IN_WIDTH, 16, width of the immediate field from the instruction.
OUT_WIDTH, 32, width of the extended result; must satisfy OUT_WIDTH >= IN_WIDTH + 2.
TAG_WIDTH, 5, width of the sideband tag carried with each entry.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous pipeline flush; empties buffer.
imediato  input  IN_WIDTH  raw immediate field.
modo  input  2  extension mode: 00 zero, 01 sign, 10 upper, 11 branch.
tag_in  input  TAG_WIDTH  sideband tag for the entry.
in_valid  input  1  imediato/modo/tag_in valid this cycle.
in_ready  output  1  stage can accept an entry this cycle.
saida  output  OUT_WIDTH  extended value at buffer head.
tag_out  output  TAG_WIDTH  tag at buffer head.
out_valid  output  1  saida/tag_out valid.
out_ready  input  1  EX consumes head this cycle.
count  output  2  entries held (0..2).

Behaviour:
- Extension, combinational on the accept path, with E = OUT_WIDTH - IN_WIDTH:
  - modo 00: zero-extend; {E zeros, imediato}.
  - modo 01: sign-extend; {E copies of imediato[IN_WIDTH-1], imediato}.
  - modo 10: upper; imediato shifted left by E, low E bits zero (LUI form).
  - modo 11: branch offset; sign-extend to OUT_WIDTH, then shift left 2. The top 2 bits of the sign-extended value are discarded; the low 2 bits are zero.
- Storage: 2-entry FIFO (head/tail pointers, or head/skid registers) plus count.
- in_ready = (count != 2). It is a registered-state function and never depends combinationally on out_ready.
- Push when in_valid && in_ready. Pop when out_valid && out_ready. out_valid = (count != 0).
- Latency: an entry accepted in cycle N is visible on saida/tag_out in cycle N+1 when the buffer was empty or popped in cycle N. Otherwise it appears after the older entry pops.
- Simultaneous push and pop:
  - count unchanged.
  - head advances to the next entry.
  - With count 1, the new entry becomes head next cycle.
- Stability: while out_valid && !out_ready, saida and tag_out hold constant.
- Ordering: strict FIFO; no entry is ever duplicated or dropped except by flush or reset.
- Full (count 2): in_ready is 0; in_valid is ignored. A pop that cycle does not allow a same-cycle push.
- Empty (count 0): out_ready is ignored; saida/tag_out hold the last head value. Both are all-zero after reset.
- flush:
  - next cycle count = 0, out_valid = 0.
  - Any push in the same cycle is discarded.
  - saida/tag_out retain their values but are invalid.
- reset: has priority over flush. Next cycle count = 0, out_valid = 0, saida = 0, tag_out = 0, pointers = 0, in_ready = 1. Applying it mid-operation discards all entries.
- Reset values: in_ready 1, out_valid 0, saida 0, tag_out 0, count 0.
- modo and tag are captured at push time; later changes to inputs do not affect stored entries.

Test Plan:
- Modes (out_ready=1), imediato 0x8001, one push per mode, tags 1..4 -> saida 0x00008001 (00), 0xFFFF8001 (01), 0x80010000 (10), 0xFFFE0004 (11), one cycle after each push, tags in order.
- Positive sign path: modo 01, imediato 0x7FFF -> 0x00007FFF. Modo 11, imediato 0xFFFF -> 0xFFFFFFFC.
- Backpressure: out_ready=0, push 0x0001 then 0x0002 (modo 00) -> count 2, in_ready 0, third push (0x0003) ignored, saida stable 0x00000001. Then out_ready=1 for 2 cycles -> 0x00000001, 0x00000002, count 0.
- Simultaneous push/pop at count 1 (head 0x00000005, push 0x0006, out_ready=1) -> count stays 1, next head 0x00000006.
- Flush at count 2 with concurrent in_valid -> next cycle count 0, out_valid 0, in_ready 1; the pushed entry never appears.
- Reset asserted at count 2 together with flush -> next cycle saida 0, tag_out 0, out_valid 0, count 0. A push right after reset release appears one cycle later.
- Parameter variant IN_WIDTH=8, OUT_WIDTH=16: modo 01, imediato 0x80 -> 0xFF80. Modo 10, imediato 0x12 -> 0x1200.
